// File: rtl/ysyx_23060236_ifu_pkg.sv
// ysyx_23060236_ifu_pkg: IFU state encoding, reset defaults and redirect next-state helper.
package ysyx_23060236_ifu_pkg;

    localparam int          ADDR_LEN_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h3000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } ifu_state_t;

    // A redirect must still swallow a response that is owed by an already accepted request.
    function automatic ifu_state_t redirect_next(input ifu_state_t s, input logic arready, input logic rvalid);
        return ((s == REQ && arready) || ((s == WAIT || s == DRAIN) && !rvalid)) ? DRAIN : REQ;
    endfunction

endpackage

// File: rtl/ysyx_23060236_ifu.sv
// ysyx_23060236_ifu: fetch PC, BTB lookup and single-outstanding icache fetch feeding the IDU.
module ysyx_23060236_ifu
    import ysyx_23060236_ifu_pkg::*;
#(
    parameter int                  ADDR_LEN = ADDR_LEN_DEF,
    parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(RESET_PC_DEF)
) (
    input  logic                clock,
    input  logic                reset,
    output logic [ADDR_LEN-1:0] btb_araddr,
    input  logic [ADDR_LEN-1:0] btb_rdata,
    output logic                icache_arvalid,
    input  logic                icache_arready,
    output logic [ADDR_LEN-1:0] icache_araddr,
    input  logic                icache_rvalid,
    input  logic [ADDR_LEN-1:0] icache_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_LEN-1:0] out_inst,
    output logic [ADDR_LEN-1:0] out_pc,
    output logic [ADDR_LEN-1:0] out_npc,
    input  logic                redirect_valid,
    input  logic [ADDR_LEN-1:0] redirect_pc
);

    ifu_state_t          r_state;
    logic [ADDR_LEN-1:0] r_pc;
    logic [ADDR_LEN-1:0] r_npc_pred;
    logic [ADDR_LEN-1:0] r_inst;
    logic [ADDR_LEN-1:0] r_out_pc;
    logic [ADDR_LEN-1:0] r_out_npc;
    logic [ADDR_LEN-1:0] w_redirect_pc;

    assign w_redirect_pc  = redirect_pc & ~ADDR_LEN'(3);
    assign btb_araddr     = r_pc;
    assign icache_araddr  = r_pc;
    assign icache_arvalid = r_state == REQ;
    // A same-cycle redirect kills the held instruction before decode can take it.
    assign out_valid      = (r_state == HOLD) & ~redirect_valid;
    assign out_inst       = r_inst;
    assign out_pc         = r_out_pc;
    assign out_npc        = r_out_npc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_npc_pred <= '0;
            r_inst     <= '0;
            r_out_pc   <= '0;
            r_out_npc  <= '0;
        end else if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= redirect_next(r_state, icache_arready, icache_rvalid);
        end else begin
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: if (icache_arready) begin
                    r_npc_pred <= btb_rdata;
                    r_state    <= WAIT;
                end
                WAIT: if (icache_rvalid) begin
                    r_inst    <= icache_rdata;
                    r_out_pc  <= r_pc;
                    r_out_npc <= r_npc_pred;
                    r_state   <= HOLD;
                end
                HOLD: if (out_ready) begin
                    r_pc    <= r_npc_pred;
                    r_state <= REQ;
                end
                DRAIN: if (icache_rvalid) r_state <= REQ;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
